// File: rtl/cpu_run_sequencer.sv
// rtl/cpu_run_sequencer.sv - run controller: core reset hold, budgeted run, stepping, breakpoint, halt
module cpu_run_sequencer #(
    parameter int CYCLE_W        = 32,
    parameter int PC_W           = 32,
    parameter int RST_CYCLES     = 2,
    parameter int DEFAULT_BUDGET = 500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [CYCLE_W-1:0] cmd_arg,
    input  logic               bp_en,
    input  logic [PC_W-1:0]    bp_addr,
    input  logic [PC_W-1:0]    core_pc,
    output logic               core_rst_n,
    output logic               core_ce,
    output logic [CYCLE_W-1:0] cycle_cnt,
    output logic [2:0]         state,
    output logic               halted,
    output logic [1:0]         halt_cause,
    output logic               done_pulse
);

    localparam logic [2:0] ST_RST_HOLD = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_RUN      = 3'd2;
    localparam logic [2:0] ST_STEP     = 3'd3;
    localparam logic [2:0] ST_HALT     = 3'd4;

    localparam logic [1:0] OP_CLEAR = 2'b00;
    localparam logic [1:0] OP_RUN   = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_HALT  = 2'b11;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_COUNT = 2'd1;
    localparam logic [1:0] CAUSE_BP    = 2'd2;
    localparam logic [1:0] CAUSE_HOST  = 2'd3;

    localparam int              RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(RST_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [RC_W-1:0]    rst_cnt_q, rst_cnt_d;
    logic [CYCLE_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CYCLE_W-1:0] rem_q, rem_d;
    logic [1:0]         halt_cause_q, halt_cause_d;
    logic               done_pulse_q, done_pulse_d;
    logic               skip_bp_q, skip_bp_d;

    logic cmd_acc;
    logic running;
    logic host_halt;
    logic bp_hit;

    // Handshake and per-cycle enable terms; core_rst_n follows the state so an async reset drops it at once
    always_comb begin
        cmd_ready  = (state_q != ST_RST_HOLD);
        cmd_acc    = cmd_valid && cmd_ready;
        running    = (state_q == ST_RUN) || (state_q == ST_STEP);
        host_halt  = running && cmd_acc && (cmd_op == OP_HALT);
        bp_hit     = running && bp_en && (core_pc == bp_addr) && !skip_bp_q;
        core_ce    = running && !bp_hit && !host_halt;
        core_rst_n = (state_q != ST_RST_HOLD);
    end

    // Next-state logic; halt priority is host > breakpoint > budget exhausted
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        rem_d        = rem_q;
        halt_cause_d = halt_cause_q;
        skip_bp_d    = skip_bp_q;
        done_pulse_d = 1'b0;
        case (state_q)
            ST_RST_HOLD: begin
                if (rst_cnt_q == RC_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_IDLE, ST_HALT: begin
                if (cmd_acc) begin
                    case (cmd_op)
                        OP_RUN: begin
                            rem_d        = (cmd_arg != '0) ? cmd_arg : CYCLE_W'(DEFAULT_BUDGET);
                            skip_bp_d    = 1'b1;
                            halt_cause_d = CAUSE_NONE;
                            state_d      = ST_RUN;
                        end
                        OP_STEP: begin
                            rem_d        = (cmd_arg != '0) ? cmd_arg : CYCLE_W'(1);
                            skip_bp_d    = 1'b1;
                            halt_cause_d = CAUSE_NONE;
                            state_d      = ST_STEP;
                        end
                        OP_CLEAR: cycle_cnt_d = '0;
                        default: begin
                            if (state_q == ST_IDLE) begin
                                state_d      = ST_HALT;
                                halt_cause_d = CAUSE_HOST;
                            end
                        end
                    endcase
                end
            end
            ST_RUN, ST_STEP: begin
                if (host_halt) begin
                    state_d      = ST_HALT;
                    halt_cause_d = CAUSE_HOST;
                end else if (bp_hit) begin
                    state_d      = ST_HALT;
                    halt_cause_d = CAUSE_BP;
                end else begin
                    if (cycle_cnt_q != '1) begin
                        cycle_cnt_d = cycle_cnt_q + 1'b1;
                    end
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                    end
                    skip_bp_d = 1'b0;
                    if (rem_q == CYCLE_W'(1)) begin
                        state_d      = ST_HALT;
                        halt_cause_d = CAUSE_COUNT;
                    end
                end
            end
            default: state_d = ST_RST_HOLD;
        endcase
        done_pulse_d = (state_d == ST_HALT) && (state_q != ST_HALT);
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RST_HOLD;
            rst_cnt_q    <= '0;
            cycle_cnt_q  <= '0;
            rem_q        <= '0;
            halt_cause_q <= CAUSE_NONE;
            done_pulse_q <= 1'b0;
            skip_bp_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
            rem_q        <= rem_d;
            halt_cause_q <= halt_cause_d;
            done_pulse_q <= done_pulse_d;
            skip_bp_q    <= skip_bp_d;
        end
    end

    assign cycle_cnt  = cycle_cnt_q;
    assign state      = state_q;
    assign halted     = (state_q == ST_HALT);
    assign halt_cause = halt_cause_q;
    assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// tb/tb_cpu_run_sequencer.sv - directed self-checking bench for cpu_run_sequencer
module tb_cpu_run_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'b00;
    logic [31:0] cmd_arg = 32'd0;
    logic        bp_en = 1'b0;
    logic [31:0] bp_addr = 32'd0;
    logic [31:0] core_pc = 32'd0;
    logic        core_rst_n;
    logic        core_ce;
    logic [31:0] cycle_cnt;
    logic [2:0]  state;
    logic        halted;
    logic [1:0]  halt_cause;
    logic        done_pulse;

    int total = 0;
    int bad   = 0;
    int n;
    logic last_ce;

    cpu_run_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .core_pc    (core_pc),
        .core_rst_n (core_rst_n),
        .core_ce    (core_ce),
        .cycle_cnt  (cycle_cnt),
        .state      (state),
        .halted     (halted),
        .halt_cause (halt_cause),
        .done_pulse (done_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cyc();
        cmd_valid = 1'b0;
    endtask

    // Counts enabled cycles until halt; a modelled PC advances by one per enabled cycle
    task automatic run_until_halt(input int maxc, output int cnt, output logic lce);
        logic fin;
        cnt = 0;
        lce = 1'b0;
        fin = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            #1;
            if (halted) begin
                fin = 1'b1;
                break;
            end
            lce = core_ce;
            if (core_ce) cnt++;
            cyc();
            if (lce) core_pc = core_pc + 32'd1;
        end
        if (!fin) chk("halt_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        // reset held for 3 cycles
        repeat (3) cyc();
        chk("rst_state", 64'(state), 64'd0);
        chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("rst_core_ce", 64'(core_ce), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("rst_cycle_cnt", 64'(cycle_cnt), 64'd0);
        rst = 1'b1;
        cyc();
        chk("hold_edge1_rst_n", 64'(core_rst_n), 64'd0);
        cyc();
        chk("hold_done_state", 64'(state), 64'd1);
        chk("hold_done_rst_n", 64'(core_rst_n), 64'd1);
        chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("idle_halt_cause", 64'(halt_cause), 64'd0);

        // default RUN budget
        send(2'b01, 32'd0);
        run_until_halt(1000, n, last_ce);
        chk("budget_ce_cycles", 64'(n), 64'd500);
        chk("budget_cycle_cnt", 64'(cycle_cnt), 64'd500);
        chk("budget_state", 64'(state), 64'd4);
        chk("budget_cause", 64'(halt_cause), 64'd1);
        chk("budget_done_pulse", 64'(done_pulse), 64'd1);
        cyc();
        chk("budget_done_pulse_drop", 64'(done_pulse), 64'd0);

        // CLEAR in HALT keeps cause
        send(2'b00, 32'd0);
        chk("clear_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("clear_cause_kept", 64'(halt_cause), 64'd1);
        chk("clear_state", 64'(state), 64'd4);

        // single steps then a multi-step
        for (int k = 0; k < 3; k++) begin
            send(2'b10, 32'd0);
            chk("step_cause_cleared", 64'(halt_cause), 64'd0);
            run_until_halt(20, n, last_ce);
            chk("step1_cycles", 64'(n), 64'd1);
        end
        chk("step3_cycle_cnt", 64'(cycle_cnt), 64'd3);
        send(2'b10, 32'd4);
        run_until_halt(20, n, last_ce);
        chk("step4_cycles", 64'(n), 64'd4);
        chk("step4_cycle_cnt", 64'(cycle_cnt), 64'd7);
        chk("step4_cause", 64'(halt_cause), 64'd1);

        // breakpoint at 0x10 reached on the 6th cycle
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        core_pc = 32'h0B;
        send(2'b01, 32'd100);
        run_until_halt(200, n, last_ce);
        chk("bp_ce_cycles", 64'(n), 64'd5);
        chk("bp_hit_cycle_ce", 64'(last_ce), 64'd0);
        chk("bp_cause", 64'(halt_cause), 64'd2);
        chk("bp_cycle_cnt", 64'(cycle_cnt), 64'd12);
        chk("bp_pc", 64'(core_pc), 64'h10);
        send(2'b01, 32'd1);
        run_until_halt(20, n, last_ce);
        chk("bp_resume_cycles", 64'(n), 64'd1);
        chk("bp_resume_cause", 64'(halt_cause), 64'd1);
        chk("bp_resume_cycle_cnt", 64'(cycle_cnt), 64'd13);

        // RUN/STEP/CLEAR dropped while running, then host HALT
        bp_en = 1'b0;
        send(2'b01, 32'd100);
        send(2'b10, 32'd5);
        chk("drop_step_ready", 64'(cmd_ready), 64'd1);
        send(2'b00, 32'd0);
        chk("drop_clear_ready", 64'(cmd_ready), 64'd1);
        send(2'b01, 32'd3);
        chk("drop_run_ready", 64'(cmd_ready), 64'd1);
        chk("drop_state", 64'(state), 64'd2);
        chk("drop_cycle_cnt", 64'(cycle_cnt), 64'd16);
        send(2'b11, 32'd0);
        chk("host_state", 64'(state), 64'd4);
        chk("host_cause", 64'(halt_cause), 64'd3);
        chk("host_cycle_cnt", 64'(cycle_cnt), 64'd16);

        // HALT coincident with breakpoint and rem==1
        bp_en   = 1'b1;
        core_pc = 32'h0F;
        send(2'b01, 32'd2);
        #1;
        chk("prio_first_ce", 64'(core_ce), 64'd1);
        cyc();
        core_pc   = 32'h10;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_arg   = 32'd0;
        #1;
        chk("prio_ce_blocked", 64'(core_ce), 64'd0);
        chk("prio_ready", 64'(cmd_ready), 64'd1);
        cyc();
        cmd_valid = 1'b0;
        chk("prio_state", 64'(state), 64'd4);
        chk("prio_cause", 64'(halt_cause), 64'd3);
        chk("prio_cycle_cnt", 64'(cycle_cnt), 64'd17);
        chk("prio_done_pulse", 64'(done_pulse), 64'd1);

        // async reset in the middle of a RUN
        bp_en = 1'b0;
        send(2'b01, 32'd0);
        repeat (36) cyc();
        chk("mid_run_cycle_cnt", 64'(cycle_cnt), 64'd53);
        #2;
        rst = 1'b0;
        #1;
        chk("async_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("async_core_ce", 64'(core_ce), 64'd0);
        chk("async_cycle_cnt", 64'(cycle_cnt), 64'd0);
        chk("async_state", 64'(state), 64'd0);
        chk("async_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("async_cause", 64'(halt_cause), 64'd0);
        cyc();
        rst = 1'b1;
        cyc();
        chk("rerst_hold", 64'(state), 64'd0);
        cyc();
        chk("rerst_idle", 64'(state), 64'd1);

        // HALT from IDLE
        send(2'b11, 32'd0);
        chk("idle_halt_state", 64'(state), 64'd4);
        chk("idle_halt_cause", 64'(halt_cause), 64'd3);
        chk("idle_halt_pulse", 64'(done_pulse), 64'd1);
        chk("idle_halt_halted", 64'(halted), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_run_sequencer.md
Name: cpu_run_sequencer

Overview:
- Synthesizable run controller for the 32-bit CPU core (cpu_controller).
- Replaces a fixed clock-and-reset stimulus: holds core reset for a programmable number of cycles, then gates the core clock-enable under host control.
- Host control modes are run for a cycle budget, single or multi-step, and halt.
- Supports a PC breakpoint; reports cycle count and halt cause.

Parameters:
CYCLE_W, 32, width of cycle counter and command argument
PC_W, 32, width of core PC and breakpoint address
RST_CYCLES, 2, cycles core_rst_n is held low after reset release (>=1)
DEFAULT_BUDGET, 500, RUN budget used when cmd_arg==0

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-low reset
cmd_valid  in  1  host command valid
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready at clk edge
cmd_op  in  2  00 CLEAR, 01 RUN, 10 STEP, 11 HALT
cmd_arg  in  CYCLE_W  RUN budget / STEP count
bp_en  in  1  breakpoint enable
bp_addr  in  PC_W  breakpoint PC
core_pc  in  PC_W  current core PC
core_rst_n  out  1  active-low reset to core
core_ce  out  1  core clock enable (combinational)
cycle_cnt  out  CYCLE_W  enabled cycles executed since reset/CLEAR
state  out  3  0 RST_HOLD, 1 IDLE, 2 RUN, 3 STEP, 4 HALT
halted  out  1  state==HALT
halt_cause  out  2  0 none, 1 count exhausted, 2 breakpoint, 3 host
done_pulse  out  1  one-cycle pulse on entry to HALT

Behaviour:
- Reset (rst=0, async) values:
  - state=RST_HOLD, core_rst_n=0, core_ce=0, cycle_cnt=0, rem=0, halt_cause=0, done_pulse=0, skip_bp=0.
  - cmd_ready=0.
- RST_HOLD:
  - Counts RST_CYCLES clk edges after rst rises; core_rst_n=0 throughout.
  - Then goes to IDLE with core_rst_n=1.
- cmd_ready:
  - cmd_ready = (state!=RST_HOLD).
  - Commands are always accepted outside RST_HOLD; ineffective ones are dropped.
- IDLE/HALT command handling:
  - RUN: rem<=(cmd_arg?cmd_arg:DEFAULT_BUDGET), skip_bp<=1, next RUN.
  - STEP: rem<=(cmd_arg?cmd_arg:1), skip_bp<=1, next STEP.
  - CLEAR: cycle_cnt<=0, state unchanged.
  - HALT: from IDLE go to HALT with cause 3; in HALT, no effect.
- RUN/STEP: RUN and STEP behave identically apart from default count. RUN/STEP/CLEAR commands are dropped.
- Per-cycle hit terms in RUN/STEP:
  - bp_hit = bp_en && core_pc==bp_addr && !skip_bp.
  - host_halt = accepted HALT this cycle.
  - core_ce = running && !bp_hit && !host_halt.
- Priority host_halt > bp_hit > count exhausted:
  - host_halt: next HALT, cause 3, rem unchanged.
  - else bp_hit: next HALT, cause 2; instruction at bp_addr not executed.
  - else (core_ce=1): cycle_cnt+1 (saturates at all-ones), rem-1, skip_bp<=0; if rem==1, next HALT with cause 1.
- skip_bp lets a resume from a breakpoint execute the breakpoint instruction once.
- done_pulse: registered; high exactly the first cycle state==HALT; also fires on IDLE->HALT.
- halt_cause: holds its value until the next RUN/STEP acceptance, which sets it to 0.
- core_ce=0 in RST_HOLD, IDLE, HALT.
- Reset mid-RUN: immediate async return to reset values; core_rst_n drops in the same instant, without waiting for a clock edge.
- rem width CYCLE_W; no arithmetic wrap (rem never decremented at 0).

Test Plan:
- Reset sequencing: rst low 3 cycles then high, RST_CYCLES=2 -> core_rst_n low through 2 edges after release, state=IDLE, cmd_ready=1, all counters 0.
- RUN budget: RUN cmd_arg=0 -> core_ce high exactly 500 cycles, cycle_cnt=500, state=HALT, halt_cause=1, done_pulse one cycle.
- Stepping: STEP arg=0 three times from HALT -> each gives 1 core_ce cycle; cycle_cnt=3; STEP arg=4 -> 4 cycles; cycle_cnt=7.
- Breakpoint: bp_en=1, bp_addr=0x10, RUN arg=100, core_pc reaches 0x10 at 6th cycle -> 5 enabled cycles, halt_cause=2, core_ce=0 in hit cycle. Next RUN arg=1 -> executes 0x10, halt_cause=1.
- Host halt priority: HALT issued same cycle as bp_hit and rem==1 -> core_ce=0, halt_cause=3, cycle_cnt unchanged; RUN/STEP/CLEAR during RUN dropped, cmd_ready stays 1.
- Async reset mid-run: rst low at RUN cycle 37 without a clk edge -> core_rst_n=0, core_ce=0, cycle_cnt=0 immediately. CLEAR in HALT -> cycle_cnt=0, halt_cause retained.
